// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, FSM states and opcode field positions for the serial ALU
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // opcode = {ainv, binv, opA, opB}
    localparam int AINV_POS = 3;
    localparam int BINV_POS = 2;
    localparam int OPA_POS  = 1;
    localparam int OPB_POS  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_serial_slice.sv
// rtl/alu_serial_slice.sv - combinational 1-bit ALU slice: operand inversion, logic ops, full adder, 4:1 select
module alu_serial_slice (
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       ainv,
    input  logic       binv,
    input  logic [1:0] op_sel,
    input  logic       less,
    input  logic       cin,
    output logic       res_bit,
    output logic       sum_bit,
    output logic       cout
);

    logic x, y;

    assign x       = a_bit ^ ainv;
    assign y       = b_bit ^ binv;
    assign sum_bit = x ^ y ^ cin;
    assign cout    = (x & y) | (x & cin) | (y & cin);

    always_comb begin
        res_bit = 1'b0;
        case (op_sel)
            2'b00:   res_bit = x & y;
            2'b01:   res_bit = x | y;
            2'b10:   res_bit = binv ? less : (x ^ y);
            default: res_bit = sum_bit;
        endcase
    end

endmodule

// File: rtl/alu_bitserial_seq.sv
// rtl/alu_bitserial_seq.sv - bit-serial ALU sequencer, LSB-first, one slice per clock
// SLT_OVF_FIX_EN: when defined, SLT uses MSB sum ^ overflow (signed-correct); otherwise the raw MSB sum.
module alu_bitserial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic [IW-1:0]    i_q, i_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;

    logic res_bit, sum_bit, carry_bit, ovf_bit, slt_bit, slt_mode;

    alu_serial_slice u_slice (
        .a_bit   (a_q[i_q]),
        .b_bit   (b_q[i_q]),
        .ainv    (op_q[AINV_POS]),
        .binv    (op_q[BINV_POS]),
        .op_sel  ({op_q[OPA_POS], op_q[OPB_POS]}),
        .less    (1'b0),
        .cin     (c_q),
        .res_bit (res_bit),
        .sum_bit (sum_bit),
        .cout    (carry_bit)
    );

    assign ovf_bit  = c_q ^ carry_bit;
    assign slt_mode = op_q[OPA_POS] & ~op_q[OPB_POS] & op_q[BINV_POS];
`ifdef SLT_OVF_FIX_EN
    assign slt_bit  = sum_bit ^ ovf_bit;
`else
    assign slt_bit  = sum_bit;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        i_d       = i_q;
        c_d       = c_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = opcode;
                    i_d     = '0;
                    c_d     = opcode[BINV_POS];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[i_q] = res_bit;
                c_d           = carry_bit;
                i_d           = i_q + IW'(1);
                if (i_q == LAST) begin
                    cout_d = carry_bit;
                    ovf_d  = ovf_bit;
                    // less-than is only known once the MSB sum exists
                    if (slt_mode) begin
                        result_d[0] = slt_bit;
                    end
                    i_d     = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            i_q      <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            i_q      <= i_d;
            c_q      <= c_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = (state_q == ST_DONE) && (result_q == '0);

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// tb/tb_alu_bitserial_seq.sv - scoreboard bench for alu_bitserial_seq with a word-level reference model
module tb_alu_bitserial_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout, overflow, zero;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
        int unsigned  acc;
        string        name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          seen = 1'b0;
    bit          rand_bp = 1'b0;

    alu_bitserial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-level model: two's-complement arithmetic on the (optionally inverted) operands
    function automatic exp_t model(input logic [W-1:0] av, bv, input logic [3:0] op, input string nm);
        exp_t         e;
        logic [W-1:0] x, y, s;
        logic [W:0]   full;
        logic         slt;
        x    = op[3] ? ~av : av;
        y    = op[2] ? ~bv : bv;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, op[2]};
        s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`ifdef SLT_OVF_FIX_EN
        slt = s[W-1] ^ e.ovf;
`else
        slt = s[W-1];
`endif
        case (op[1:0])
            2'b00:   e.res = x & y;
            2'b01:   e.res = x | y;
            2'b10:   e.res = op[2] ? {{(W-1){1'b0}}, slt} : (x ^ y);
            default: e.res = s;
        endcase
        e.zero = (e.res == '0);
        e.acc  = 0;
        e.name = nm;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // Monitor: checks latency on the first cycle of out_valid, pops on handshake
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                timeout_fail("unexpected_out_valid");
            end else begin
                if (!seen) begin
                    chk({sb[0].name, "_latency"}, W'(cyc - sb[0].acc), W'(W));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_result"}, result, mon_e.res);
                    chk({mon_e.name, "_cout"}, W'(cout), W'(mon_e.cout));
                    chk({mon_e.name, "_overflow"}, W'(overflow), W'(mon_e.ovf));
                    chk({mon_e.name, "_zero"}, W'(zero), W'(mon_e.zero));
                    seen = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accept edge
    task automatic send(input logic [W-1:0] av, bv, input logic [3:0] op, input string nm);
        exp_t e;
        int   n = 0;
        a = av; b = bv; opcode = op; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 400);
        if (!in_ready) begin
            timeout_fail({nm, "_accept"});
            @(posedge clk); #1 in_valid = 1'b0;
            return;
        end
        e = model(av, bv, op, nm);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) timeout_fail({nm, "_drain"});
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e1;
        int   n;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_result", result, '0);
        chk("rst_flags", W'({cout, overflow, zero}), '0);
        @(posedge clk); #1 reset = 1'b0;

        send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, "add_ovf");
        send(32'h0000_0005, 32'h0000_0005, OP_SUB, "sub_eq");
        send(32'h8000_0000, 32'h0000_0001, OP_SLT, "slt_min");
        send(32'hF0F0_F0F0, 32'h0F0F_0000, OP_NOR, "nor");
        send(32'hF0F0_F0F0, 32'h0F0F_0000, OP_AND, "and_zero");
        send(32'h1234_5678, 32'h0F0F_F0F0, OP_OR,  "or");
        send(32'h1234_5678, 32'h0F0F_F0F0, OP_XOR, "xor");
        send(32'h0000_0001, 32'h0000_0002, OP_SLT, "slt_small");
        wait_drain("directed");

        // Back-pressure: hold DONE for 10 cycles while a second op is offered
        out_ready = 1'b0;
        e1 = model(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, "bp1");
        send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, "bp1");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 3 * W);
        if (!out_valid) timeout_fail("bp_out_valid");
        @(posedge clk); #1;
        a = 32'h0000_0009; b = 32'h0000_0003; opcode = OP_SUB; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_out_valid", W'(out_valid), W'(1));
            chk("bp_hold_in_ready", W'(in_ready), '0);
            chk("bp_hold_result", result, e1.res);
            chk("bp_hold_flags", W'({cout, overflow, zero}), W'({e1.cout, e1.ovf, e1.zero}));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h0000_0009, 32'h0000_0003, OP_SUB, "bp2");
        wait_drain("bp");

        // Reset in the middle of RUN
        send(32'h0000_1111, 32'h0000_2222, OP_ADD, "aborted");
        repeat (12) @(posedge clk);
        #1;
        chk("midrun_in_ready", W'(in_ready), '0);
        reset = 1'b1;
        #1;
        sb.delete();
        chk("midrun_rst_in_ready", W'(in_ready), W'(1));
        chk("midrun_rst_out_valid", W'(out_valid), '0);
        chk("midrun_rst_result", result, '0);
        chk("midrun_rst_flags", W'({cout, overflow, zero}), '0);
        @(posedge clk); #1 reset = 1'b0;
        send(32'h0000_0003, 32'h0000_0004, OP_ADD, "add_3_4");
        wait_drain("post_reset");

        // Random operations over all 16 opcodes with random output stalls
        rand_bp = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send(32'($urandom), 32'($urandom), 4'($urandom_range(0, 15)), "rand");
        end
        rand_bp = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        wait_drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
